// File: rtl/emu_rst_gen.sv
// emu_rst_gen: emulation reset sequencer (lock synchronizer, hold counter, run-time stamp, exit counter).
// Build macro EMU_TIME_SAT_EN: emu_time saturates at all-ones instead of wrapping.
module emu_rst_gen #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned TIME_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  rst_req,
    output logic                  emu_rst,
    output logic [TIME_WIDTH-1:0] emu_time,
    output logic [7:0]            rst_events
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam logic [15:0]           HOLD_LOAD = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0]           CNT_ONE   = 16'd1;
    localparam logic [TIME_WIDTH-1:0] TIME_ONE  = {{(TIME_WIDTH-1){1'b0}}, 1'b1};
`ifdef EMU_TIME_SAT_EN
    localparam logic [TIME_WIDTH-1:0] TIME_MAX  = '1;
`endif

    state_t      state;
    state_t      next_state;
    logic [15:0] cnt;
    logic [15:0] next_cnt;
    logic        locked_meta;
    logic        locked_s;
    logic        leave_run;

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            WAIT_LOCK: begin
                if (locked_s) begin
                    next_state = HOLD;
                    next_cnt   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                end else if (cnt != '0) begin
                    next_cnt = cnt - CNT_ONE;
                end else if (!rst_req) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                end else if (rst_req) begin
                    next_state = HOLD;
                    next_cnt   = HOLD_LOAD;
                end
            end
            default: next_state = WAIT_LOCK;
        endcase
    end

    assign leave_run = (state == RUN) && (next_state != RUN);

    // Decoded from the state register alone: no input reaches emu_rst combinationally.
    assign emu_rst = (state != RUN);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
            state       <= WAIT_LOCK;
            cnt         <= '0;
            emu_time    <= '0;
            rst_events  <= '0;
        end else begin
            locked_meta <= locked;
            locked_s    <= locked_meta;
            state       <= next_state;
            cnt         <= next_cnt;

            // Zero on the first RUN cycle and whenever emu_rst will be high.
            if (next_state != RUN || state != RUN) begin
                emu_time <= '0;
`ifdef EMU_TIME_SAT_EN
            end else if (emu_time != TIME_MAX) begin
                emu_time <= emu_time + TIME_ONE;
`else
            end else begin
                emu_time <= emu_time + TIME_ONE;
`endif
            end

            if (leave_run && rst_events != 8'hFF) begin
                rst_events <= rst_events + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_emu_rst_gen.sv
// Directed self-checking bench for emu_rst_gen (HOLD_CYCLES=4, TIME_WIDTH=8).
module tb_emu_rst_gen;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       rst_req;
    logic       emu_rst;
    logic [7:0] emu_time;
    logic [7:0] rst_events;

    int n_cmp = 0;
    int n_err = 0;

    emu_rst_gen #(
        .HOLD_CYCLES (4),
        .TIME_WIDTH  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .locked     (locked),
        .rst_req    (rst_req),
        .emu_rst    (emu_rst),
        .emu_time   (emu_time),
        .rst_events (rst_events)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [63:0] exp_overflow;
`ifdef EMU_TIME_SAT_EN
        exp_overflow = 64'd255;
`else
        exp_overflow = 64'd44;
`endif
        rst     = 1'b1;
        locked  = 1'b1;
        rst_req = 1'b0;
        tick(3);
        check("reset_emu_rst", 64'(emu_rst), 64'd1);
        check("reset_emu_time", 64'(emu_time), 64'd0);
        check("reset_events", 64'(rst_events), 64'd0);
        check("reset_state", 64'(dut.state), 64'd0);

        // Startup: emu_rst falls on cycle HOLD_CYCLES+3 = 7
        rst = 1'b0;
        tick(6);
        check("startup_c6_emu_rst", 64'(emu_rst), 64'd1);
        tick(1);
        check("startup_c7_emu_rst", 64'(emu_rst), 64'd0);
        check("startup_c7_time", 64'(emu_time), 64'd0);
        tick(5);
        check("startup_c12_time", 64'(emu_time), 64'd5);
        check("startup_events", 64'(rst_events), 64'd0);

        // One-cycle request: emu_rst high for exactly 4 cycles
        rst_req = 1'b1;
        tick(1);
        rst_req = 1'b0;
        check("req_c1_emu_rst", 64'(emu_rst), 64'd1);
        check("req_c1_time", 64'(emu_time), 64'd0);
        check("req_events", 64'(rst_events), 64'd1);
        tick(3);
        check("req_c4_emu_rst", 64'(emu_rst), 64'd1);
        check("req_c4_cnt", 64'(dut.cnt), 64'd0);
        tick(1);
        check("req_c5_emu_rst", 64'(emu_rst), 64'd0);
        check("req_c5_time", 64'(emu_time), 64'd0);
        tick(1);
        check("req_c6_time", 64'(emu_time), 64'd1);

        // Held request for 20 cycles
        rst_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            check("held_emu_rst", 64'(emu_rst), 64'd1);
            if (i >= 4) check("held_cnt_zero", 64'(dut.cnt), 64'd0);
        end
        rst_req = 1'b0;
        tick(1);
        check("held_release_emu_rst", 64'(emu_rst), 64'd0);
        check("held_release_time", 64'(emu_time), 64'd0);
        check("held_events", 64'(rst_events), 64'd2);

        // Lock loss while rst_req=1
        tick(2);
        locked  = 1'b0;
        rst_req = 1'b1;
        tick(1);
        check("lockloss_c1_state", 64'(dut.state), 64'd1);
        check("lockloss_c1_events", 64'(rst_events), 64'd3);
        tick(1);
        check("lockloss_c2_state", 64'(dut.state), 64'd1);
        tick(1);
        check("lockloss_c3_state", 64'(dut.state), 64'd0);
        check("lockloss_c3_events", 64'(rst_events), 64'd3);
        tick(4);
        check("waitlock_req_state", 64'(dut.state), 64'd0);
        check("waitlock_req_emu_rst", 64'(emu_rst), 64'd1);
        check("waitlock_req_events", 64'(rst_events), 64'd3);

        // Re-lock repeats startup timing
        rst_req = 1'b0;
        locked  = 1'b1;
        tick(6);
        check("relock_c6_emu_rst", 64'(emu_rst), 64'd1);
        tick(1);
        check("relock_c7_emu_rst", 64'(emu_rst), 64'd0);
        check("relock_c7_time", 64'(emu_time), 64'd0);

        // Overflow of 8-bit emu_time after 300 RUN cycles
        tick(300);
        check("overflow_time", 64'(emu_time), exp_overflow);
        check("overflow_emu_rst", 64'(emu_rst), 64'd0);

        // rst_events saturation over 260 pulses (starting from 3)
        for (int p = 0; p < 260; p++) begin
            rst_req = 1'b1;
            tick(1);
            rst_req = 1'b0;
            tick(4);
            if (p == 250) check("events_254", 64'(rst_events), 64'd254);
            if (p == 251) check("events_255", 64'(rst_events), 64'd255);
        end
        check("events_saturated", 64'(rst_events), 64'd255);
        check("sat_emu_rst", 64'(emu_rst), 64'd0);

        // Reset asserted mid-HOLD
        rst_req = 1'b1;
        tick(1);
        rst_req = 1'b0;
        tick(1);
        check("midhold_state", 64'(dut.state), 64'd1);
        check("midhold_cnt", 64'(dut.cnt), 64'd2);
        rst = 1'b1;
        tick(1);
        check("midhold_rst_emu_rst", 64'(emu_rst), 64'd1);
        check("midhold_rst_time", 64'(emu_time), 64'd0);
        check("midhold_rst_events", 64'(rst_events), 64'd0);
        check("midhold_rst_state", 64'(dut.state), 64'd0);
        check("midhold_rst_cnt", 64'(dut.cnt), 64'd0);
        check("midhold_rst_sync", 64'(dut.locked_s), 64'd0);
        rst = 1'b0;
        tick(6);
        check("restart_c6_emu_rst", 64'(emu_rst), 64'd1);
        tick(1);
        check("restart_c7_emu_rst", 64'(emu_rst), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/emu_rst_gen.md
EMU_RST_GEN -- requirements
Module: emu_rst_gen

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 16, giving the number of cycles emu_rst is held after lock or a reset request; legal range 1..65535.
REQ-002 The block SHALL have parameter TIME_WIDTH, default 32, giving the emulation time counter width; legal range 8..64.
REQ-003 Port clk SHALL be input, 1 bit: emulation clock; the only clock.
REQ-004 Port rst SHALL be input, 1 bit: synchronous, active-high block reset.
REQ-005 Port locked SHALL be input, 1 bit: clock-generator lock flag, asynchronous to clk.
REQ-006 Port rst_req SHALL be input, 1 bit: level reset request from the debug probe, synchronous to clk.
REQ-007 Port emu_rst SHALL be output, 1 bit: reset delivered to the testbench; active-high.
REQ-008 Port emu_time SHALL be output, TIME_WIDTH bits: count of clk cycles since emu_rst last deasserted.
REQ-009 Port rst_events SHALL be output, 8 bits: count of RUN exits.

Function
REQ-010 locked SHALL pass through a 2-flop synchronizer; internal locked_s is locked delayed by 2 clk.
REQ-011 The FSM SHALL have states WAIT_LOCK, HOLD and RUN, plus a 16-bit down counter cnt.
REQ-012 In WAIT_LOCK with locked_s=1, the FSM SHALL go to HOLD and load cnt=HOLD_CYCLES-1.
REQ-013 In HOLD with locked_s=0, the FSM SHALL go to WAIT_LOCK; this has priority over every other HOLD transition.
REQ-014 In HOLD with cnt>0, cnt SHALL decrement.
REQ-015 In HOLD with cnt=0 and rst_req=1, the FSM SHALL remain in HOLD with cnt held at 0.
REQ-016 In HOLD with cnt=0 and rst_req=0, the FSM SHALL go to RUN.
REQ-017 In RUN with locked_s=0, the FSM SHALL go to WAIT_LOCK; this has priority over rst_req.
REQ-018 In RUN with rst_req=1, the FSM SHALL go to HOLD and reload cnt=HOLD_CYCLES-1.
REQ-019 emu_rst SHALL be 1 in every state except RUN and SHALL be decoded from the state register only, with no combinational path from any input.
REQ-020 With locked=1 from reset release, emu_rst SHALL deassert exactly HOLD_CYCLES+3 cycles after the first rising edge with rst=0.
REQ-021 emu_time SHALL read 0 while emu_rst=1 and SHALL increment by 1 on each RUN cycle.
REQ-022 At all-ones, emu_time SHALL follow REQ-030.
REQ-023 rst_events SHALL increment on each RUN->HOLD and RUN->WAIT_LOCK transition and SHALL saturate at 255.
REQ-024 rst_events SHALL be cleared only by rst.
REQ-025 rst_req asserted in WAIT_LOCK SHALL have no effect; it is evaluated only at HOLD exit.

Reset
REQ-026 While rst=1 the block SHALL set state=WAIT_LOCK, cnt=0, emu_rst=1, emu_time=0, rst_events=0, and both synchronizer flops to 0.
REQ-027 rst asserted mid-RUN or mid-HOLD SHALL take effect on the next clk edge, override all other inputs, and not increment rst_events.

Configuration
REQ-028 Macro EMU_TIME_SAT_EN SHALL control emu_time overflow behaviour.
REQ-029 With EMU_TIME_SAT_EN undefined, emu_time SHALL wrap from all-ones to 0 and continue counting.
REQ-030 With EMU_TIME_SAT_EN defined, emu_time SHALL hold at all-ones until emu_rst asserts.

Verification
REQ-031 Startup: HOLD_CYCLES=4, locked=1, rst_req=0, rst released -> emu_rst falls on cycle 7, emu_time=0 on cycle 7 and 5 on cycle 12, rst_events=0.
REQ-032 Request: in RUN, rst_req pulsed high for 1 cycle -> emu_rst=1 for exactly 4 cycles, then emu_time restarts from 0, rst_events=1.
REQ-033 Held request: rst_req held high for 20 cycles -> emu_rst stays high until the cycle after rst_req falls, with cnt at 0 throughout the tail.
REQ-034 Lock loss: locked dropped in RUN while rst_req=1 -> FSM enters WAIT_LOCK 3 cycles after the drop, rst_events increments by 1 only, and re-lock repeats REQ-031 timing.
REQ-035 Overflow: TIME_WIDTH=8, run 300 cycles -> emu_time=44 with EMU_TIME_SAT_EN undefined, 255 with it defined.
REQ-036 Saturation and reset: 260 rst_req pulses -> rst_events=255; then rst asserted mid-HOLD -> all outputs at reset values on the next cycle.
